// File: rtl/e203_itcm_ctrl_pkg.sv
// Shared definitions for the ITCM SRAM controller.
// Holds the sequencer state encoding, the response-owner encoding and the
// widths of the idle, wake and starvation counters.
package e203_itcm_ctrl_pkg;

  // Sequencer states: normal operation, light sleep, and the wake-up window
  // during which the macro is out of light sleep but not yet accessible.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLEEP = 2'd1,
    ST_WAKE  = 2'd2
  } itcm_state_e;

  // Which requester owns an in-flight or held response.
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } itcm_owner_e;

  // Counter widths sized for the legal parameter ranges
  // (idle threshold up to 255, wake latency and starve limit up to 15).
  localparam int LS_CNT_W     = 8;
  localparam int WAKE_CNT_W   = 4;
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/e203_itcm_rsp_buf.sv
// One-entry response hold buffer with bypass.
// The SRAM read data is only valid for one cycle, so when the owning
// requester does not take the response in that cycle the data is parked
// here and presented until it is accepted.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   byp_valid   response arriving straight from the SRAM this cycle
//   byp_owner   requester that owns the arriving response
//   byp_data    arriving response data (already zeroed for writes)
//   take        the owner of the presented response accepts it this cycle
//   out_valid   a response is presented
//   out_owner   owner of the presented response
//   out_data    presented response data
//   hold_valid  the hold entry is occupied
module e203_itcm_rsp_buf
  import e203_itcm_ctrl_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          byp_valid,
  input  itcm_owner_e   byp_owner,
  input  logic [DW-1:0] byp_data,
  input  logic          take,
  output logic          out_valid,
  output itcm_owner_e   out_owner,
  output logic [DW-1:0] out_data,
  output logic          hold_valid
);

  logic          hold_valid_r;
  itcm_owner_e   hold_owner_r;
  logic [DW-1:0] hold_data_r;

  // Hold entry: capture an untaken bypass response, release it on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_r <= 1'b0;
      hold_owner_r <= OWN_IFU;
      hold_data_r  <= {DW{1'b0}};
    end else if (hold_valid_r) begin
      hold_valid_r <= ~take;
    end else if (byp_valid && !take) begin
      hold_valid_r <= 1'b1;
      hold_owner_r <= byp_owner;
      hold_data_r  <= byp_data;
    end else begin
      hold_valid_r <= 1'b0;
    end
  end

  // Presentation mux: the held entry has priority over the bypass path.
  always_comb begin
    out_valid = byp_valid;
    out_owner = byp_owner;
    out_data  = byp_data;
    if (hold_valid_r) begin
      out_valid = 1'b1;
      out_owner = hold_owner_r;
      out_data  = hold_data_r;
    end else begin
      out_valid = byp_valid;
      out_owner = byp_owner;
      out_data  = byp_data;
    end
  end

  assign hold_valid = hold_valid_r;

endmodule

// File: rtl/e203_itcm_ram_ctrl.sv
// ITCM SRAM controller: shares one single-port SRAM between the IFU fetch
// port (read-only) and the LSU port (read/write with byte mask).
// Handles the fixed one-cycle read latency, response holding, LSU-priority
// arbitration with an IFU anti-starvation limit, and light-sleep entry/exit.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_ls_en                   light-sleep entry allowed
//   ifu_cmd_*/ifu_rsp_*         IFU read request / response handshake
//   lsu_cmd_*/lsu_rsp_*         LSU read-write request / response handshake
//   ram_cs/we/addr/wem/din      SRAM command, driven in the grant cycle
//   ram_dout                    SRAM read data, valid one cycle after a read
//   ram_ls/ram_ds/ram_sd        SRAM power controls (ds, sd held low)
module e203_itcm_ram_ctrl
  import e203_itcm_ctrl_pkg::*;
#(
  parameter int AW       = 13,
  parameter int DW       = 64,
  parameter int MW       = 8,
  parameter int LS_IDLE  = 16,
  parameter int WAKE_LAT = 2,
  parameter int STARVE   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_ls_en,
  input  logic          ifu_cmd_valid,
  output logic          ifu_cmd_ready,
  input  logic [AW-1:0] ifu_cmd_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          lsu_cmd_valid,
  output logic          lsu_cmd_ready,
  input  logic          lsu_cmd_read,
  input  logic [AW-1:0] lsu_cmd_addr,
  input  logic [DW-1:0] lsu_cmd_wdata,
  input  logic [MW-1:0] lsu_cmd_wmask,
  output logic          lsu_rsp_valid,
  input  logic          lsu_rsp_ready,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ls,
  output logic          ram_ds,
  output logic          ram_sd
);

  localparam logic [LS_CNT_W-1:0]     LS_IDLE_C   = LS_CNT_W'(LS_IDLE);
  localparam logic [WAKE_CNT_W-1:0]   WAKE_LAST_C = WAKE_CNT_W'(WAKE_LAT - 1);
  localparam logic [STARVE_CNT_W-1:0] STARVE_C    = STARVE_CNT_W'(STARVE);

  itcm_state_e             state_r, state_nxt_s;
  logic [LS_CNT_W-1:0]     idle_cnt_r, idle_cnt_nxt_s;
  logic [WAKE_CNT_W-1:0]   wake_cnt_r, wake_cnt_nxt_s;
  logic [STARVE_CNT_W-1:0] starve_cnt_r, starve_cnt_nxt_s;

  // Response in flight: a grant was made last cycle, ram_dout is valid now.
  logic                    pend_r;
  itcm_owner_e             pend_owner_r;
  logic                    pend_read_r;
  logic [DW-1:0]           pend_data_s;

  logic                    buf_valid_s;
  itcm_owner_e             buf_owner_s;
  logic [DW-1:0]           buf_data_s;
  logic                    hold_valid_s;

  logic                    any_valid_s;
  logic                    take_s;
  logic                    can_issue_s;
  logic                    grant_ifu_s;
  logic                    grant_lsu_s;
  logic                    grant_any_s;

  // Writes respond with zero data; reads bypass the SRAM output directly.
  assign pend_data_s = pend_read_r ? ram_dout : {DW{1'b0}};

  e203_itcm_rsp_buf #(
    .DW (DW)
  ) u_rsp_buf (
    .clk        (clk),
    .rst        (rst),
    .byp_valid  (pend_r),
    .byp_owner  (pend_owner_r),
    .byp_data   (pend_data_s),
    .take       (take_s),
    .out_valid  (buf_valid_s),
    .out_owner  (buf_owner_s),
    .out_data   (buf_data_s),
    .hold_valid (hold_valid_s)
  );

  // Arbitration: a new command may issue when the presented response (bypass
  // or held) is absent or is being taken this cycle, which keeps one access
  // per cycle while responses flow. LSU wins ties until IFU hits the limit.
  always_comb begin
    any_valid_s = ifu_cmd_valid | lsu_cmd_valid;
    take_s      = (buf_owner_s == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
    can_issue_s = ~rst & (state_r == ST_IDLE) & (~buf_valid_s | take_s);
    grant_ifu_s = can_issue_s & ifu_cmd_valid &
                  (~lsu_cmd_valid | (starve_cnt_r == STARVE_C));
    grant_lsu_s = can_issue_s & lsu_cmd_valid & ~grant_ifu_s;
    grant_any_s = grant_ifu_s | grant_lsu_s;
  end

  assign ifu_cmd_ready = grant_ifu_s;
  assign lsu_cmd_ready = grant_lsu_s;

  // SRAM command driven combinationally from the winner of this cycle.
  always_comb begin
    ram_cs   = grant_any_s;
    ram_we   = 1'b0;
    ram_addr = {AW{1'b0}};
    ram_wem  = {MW{1'b0}};
    ram_din  = {DW{1'b0}};
    if (grant_lsu_s) begin
      ram_addr = lsu_cmd_addr;
      ram_we   = ~lsu_cmd_read;
      ram_wem  = lsu_cmd_read ? {MW{1'b0}} : lsu_cmd_wmask;
      ram_din  = lsu_cmd_read ? {DW{1'b0}} : lsu_cmd_wdata;
    end else if (grant_ifu_s) begin
      ram_addr = ifu_cmd_addr;
    end else begin
      ram_addr = {AW{1'b0}};
    end
  end

  // Response steering to the owning port; data is zero when nothing is shown.
  always_comb begin
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    ifu_rsp_rdata = {DW{1'b0}};
    lsu_rsp_rdata = {DW{1'b0}};
    if (!rst && buf_valid_s) begin
      if (buf_owner_s == OWN_LSU) begin
        lsu_rsp_valid = 1'b1;
        lsu_rsp_rdata = buf_data_s;
      end else begin
        ifu_rsp_valid = 1'b1;
        ifu_rsp_rdata = buf_data_s;
      end
    end else begin
      ifu_rsp_valid = 1'b0;
      lsu_rsp_valid = 1'b0;
    end
  end

  // Sleep sequencer next state; a command arriving on the threshold cycle
  // keeps the controller awake.
  always_comb begin
    state_nxt_s    = state_r;
    wake_cnt_nxt_s = wake_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if ((idle_cnt_r == LS_IDLE_C) && cfg_ls_en && !any_valid_s) begin
          state_nxt_s = ST_SLEEP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SLEEP: begin
        if (any_valid_s || !cfg_ls_en) begin
          state_nxt_s    = ST_WAKE;
          wake_cnt_nxt_s = {WAKE_CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_SLEEP;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_r == WAKE_LAST_C) begin
          state_nxt_s = ST_IDLE;
        end else begin
          wake_cnt_nxt_s = wake_cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        wake_cnt_nxt_s = {WAKE_CNT_W{1'b0}};
      end
    endcase
  end

  // Idle and starvation counters.
  always_comb begin
    idle_cnt_nxt_s   = idle_cnt_r;
    starve_cnt_nxt_s = starve_cnt_r;
    if (state_r != ST_IDLE) begin
      idle_cnt_nxt_s = {LS_CNT_W{1'b0}};
    end else if (any_valid_s || grant_any_s) begin
      idle_cnt_nxt_s = {LS_CNT_W{1'b0}};
    end else if (!buf_valid_s && (idle_cnt_r != LS_IDLE_C)) begin
      idle_cnt_nxt_s = idle_cnt_r + 8'd1;
    end else begin
      idle_cnt_nxt_s = idle_cnt_r;
    end
    if (grant_ifu_s) begin
      starve_cnt_nxt_s = {STARVE_CNT_W{1'b0}};
    end else if (grant_lsu_s && ifu_cmd_valid && (starve_cnt_r != STARVE_C)) begin
      starve_cnt_nxt_s = starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // State, counters and in-flight response tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      idle_cnt_r   <= {LS_CNT_W{1'b0}};
      wake_cnt_r   <= {WAKE_CNT_W{1'b0}};
      starve_cnt_r <= {STARVE_CNT_W{1'b0}};
      pend_r       <= 1'b0;
      pend_owner_r <= OWN_IFU;
      pend_read_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      idle_cnt_r   <= idle_cnt_nxt_s;
      wake_cnt_r   <= wake_cnt_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
      pend_r       <= grant_any_s;
      pend_owner_r <= grant_lsu_s ? OWN_LSU : OWN_IFU;
      pend_read_r  <= ~(grant_lsu_s & ~lsu_cmd_read);
    end
  end

  assign ram_ls = ~rst & (state_r == ST_SLEEP);
  assign ram_ds = 1'b0;
  assign ram_sd = 1'b0;

endmodule

// File: tb/tb_e203_itcm_ram_ctrl.sv
// Directed self-checking bench for e203_itcm_ram_ctrl.
// A small SRAM model preloads word a with {8'hA0, 24'(a), 8'h5B, 24'(a)} on
// reset and drives a poison value on ram_dout whenever no read was issued.
module tb_e203_itcm_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_ls_en;
  logic        ifu_cmd_valid, ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [12:0] ifu_cmd_addr;
  logic [63:0] ifu_rsp_rdata;
  logic        lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read, lsu_rsp_valid, lsu_rsp_ready;
  logic [12:0] lsu_cmd_addr;
  logic [63:0] lsu_cmd_wdata, lsu_rsp_rdata;
  logic [7:0]  lsu_cmd_wmask;
  logic        ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wem;
  logic [63:0] ram_din;
  logic [63:0] ram_dout;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] W10 = 64'hA000_0010_5B00_0010;
  localparam logic [63:0] W11 = 64'hA000_0011_5B00_0011;
  localparam logic [63:0] W20_WR = 64'hA000_0020_0123_4567;

  logic [63:0] mem [0:63];

  e203_itcm_ram_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_ls_en     (cfg_ls_en),
    .ifu_cmd_valid (ifu_cmd_valid),
    .ifu_cmd_ready (ifu_cmd_ready),
    .ifu_cmd_addr  (ifu_cmd_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_rdata (ifu_rsp_rdata),
    .lsu_cmd_valid (lsu_cmd_valid),
    .lsu_cmd_ready (lsu_cmd_ready),
    .lsu_cmd_read  (lsu_cmd_read),
    .lsu_cmd_addr  (lsu_cmd_addr),
    .lsu_cmd_wdata (lsu_cmd_wdata),
    .lsu_cmd_wmask (lsu_cmd_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rsp_rdata (lsu_rsp_rdata),
    .ram_cs        (ram_cs),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wem       (ram_wem),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout),
    .ram_ls        (ram_ls),
    .ram_ds        (ram_ds),
    .ram_sd        (ram_sd)
  );

  always #5 clk = ~clk;

  // SRAM model: preload on reset, byte-masked writes, one-cycle reads.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= {8'hA0, 24'(i), 8'h5B, 24'(i)};
      end
      ram_dout <= 64'h0;
    end else if (ram_cs && ram_we) begin
      for (int b = 0; b < 8; b++) begin
        if (ram_wem[b]) mem[ram_addr[5:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
      end
      ram_dout <= 64'hDEAD_DEAD_DEAD_DEAD;
    end else if (ram_cs) begin
      ram_dout <= mem[ram_addr[5:0]];
    end else begin
      ram_dout <= 64'hDEAD_DEAD_DEAD_DEAD;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_ls_en = 1'b0;
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h10; ifu_rsp_ready = 1'b1;
    lsu_cmd_valid = 1'b0; lsu_cmd_read = 1'b1; lsu_cmd_addr = 13'h0;
    lsu_cmd_wdata = 64'h0; lsu_cmd_wmask = 8'h0; lsu_rsp_ready = 1'b1;

    // Reset: outputs low even with a request pending.
    @(negedge clk); #1;
    chk("rst_ifu_ready", 64'(ifu_cmd_ready), 64'd0);
    chk("rst_ram_cs", 64'(ram_cs), 64'd0);
    chk("rst_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'd0);
    chk("rst_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
    chk("rst_ram_ls", 64'(ram_ls), 64'd0);
    @(negedge clk); rst = 1'b0; ifu_cmd_valid = 1'b0;

    // IFU back-to-back reads 0x10, 0x11.
    @(negedge clk); ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h10; #1;
    chk("ifu0_ready", 64'(ifu_cmd_ready), 64'd1);
    chk("ifu0_cs", 64'(ram_cs), 64'd1);
    chk("ifu0_addr", 64'(ram_addr), 64'h10);
    chk("ifu0_we", 64'(ram_we), 64'd0);
    @(negedge clk); ifu_cmd_addr = 13'h11; #1;
    chk("ifu1_cs", 64'(ram_cs), 64'd1);
    chk("ifu1_addr", 64'(ram_addr), 64'h11);
    chk("ifu0_rsp_valid", 64'(ifu_rsp_valid), 64'd1);
    chk("ifu0_rsp_data", ifu_rsp_rdata, W10);
    @(negedge clk); ifu_cmd_valid = 1'b0; #1;
    chk("ifu_idle_cs", 64'(ram_cs), 64'd0);
    chk("ifu1_rsp_valid", 64'(ifu_rsp_valid), 64'd1);
    chk("ifu1_rsp_data", ifu_rsp_rdata, W11);
    @(negedge clk); #1;
    chk("ifu_rsp_drop", 64'(ifu_rsp_valid), 64'd0);

    // LSU masked write then read back.
    @(negedge clk);
    lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b0; lsu_cmd_addr = 13'h20;
    lsu_cmd_wdata = 64'hDEAD_BEEF_0123_4567; lsu_cmd_wmask = 8'h0F; #1;
    chk("wr_ready", 64'(lsu_cmd_ready), 64'd1);
    chk("wr_we", 64'(ram_we), 64'd1);
    chk("wr_wem", 64'(ram_wem), 64'h0F);
    chk("wr_din", ram_din, 64'hDEAD_BEEF_0123_4567);
    @(negedge clk); lsu_cmd_read = 1'b1; lsu_cmd_wmask = 8'hFF; #1;
    chk("rd_we", 64'(ram_we), 64'd0);
    chk("rd_wem", 64'(ram_wem), 64'h00);
    chk("wr_rsp_valid", 64'(lsu_rsp_valid), 64'd1);
    chk("wr_rsp_data", lsu_rsp_rdata, 64'h0);
    chk("wr_rsp_not_ifu", 64'(ifu_rsp_valid), 64'd0);
    @(negedge clk); lsu_cmd_valid = 1'b0; #1;
    chk("rd_rsp_valid", 64'(lsu_rsp_valid), 64'd1);
    chk("rd_rsp_data", lsu_rsp_rdata, W20_WR);

    // Both requesting every cycle: L,L,L,L,I repeating.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h10;
      lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 13'h20; #1;
      chk($sformatf("arb%0d_ifu", i), 64'(ifu_cmd_ready), 64'((i % 5) == 4));
      chk($sformatf("arb%0d_lsu", i), 64'(lsu_cmd_ready), 64'((i % 5) != 4));
    end
    @(negedge clk); ifu_cmd_valid = 1'b0; lsu_cmd_valid = 1'b0; #1;
    chk("arb_last_rsp", ifu_rsp_rdata, W10);

    // LSU response stalled for three cycles: data held, no new issue.
    @(negedge clk);
    lsu_rsp_ready = 1'b0; lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 13'h11; #1;
    chk("hold_grant", 64'(lsu_cmd_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); lsu_cmd_addr = 13'h10; #1;
      chk($sformatf("hold%0d_valid", i), 64'(lsu_rsp_valid), 64'd1);
      chk($sformatf("hold%0d_data", i), lsu_rsp_rdata, W11);
      chk($sformatf("hold%0d_cs", i), 64'(ram_cs), 64'd0);
      chk($sformatf("hold%0d_ready", i), 64'(lsu_cmd_ready), 64'd0);
    end
    @(negedge clk); lsu_rsp_ready = 1'b1; #1;
    chk("hold_accept_data", lsu_rsp_rdata, W11);
    chk("hold_accept_grant", 64'(lsu_cmd_ready), 64'd1);
    chk("hold_accept_addr", 64'(ram_addr), 64'h10);
    @(negedge clk); lsu_cmd_valid = 1'b0; #1;
    chk("hold_next_data", lsu_rsp_rdata, W10);

    // Reset the cycle after a grant drops the response.
    @(negedge clk); ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h10; #1;
    chk("rstx_grant", 64'(ifu_cmd_ready), 64'd1);
    @(negedge clk); ifu_cmd_valid = 1'b0; rst = 1'b1; #1;
    chk("rstx_rsp_during", 64'(ifu_rsp_valid), 64'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rstx_rsp_after", 64'(ifu_rsp_valid), 64'd0);
    chk("rstx_cs_after", 64'(ram_cs), 64'd0);
    @(negedge clk); ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h11; #1;
    chk("rstx_resume_grant", 64'(ifu_cmd_ready), 64'd1);
    @(negedge clk); ifu_cmd_valid = 1'b0; #1;
    chk("rstx_resume_data", ifu_rsp_rdata, W11);

    // Light sleep after 16 idle cycles, then wake on an IFU request.
    @(negedge clk); cfg_ls_en = 1'b1; #1;
    chk("ls_start", 64'(ram_ls), 64'd0);
    repeat (16) @(negedge clk);
    #1;
    chk("ls_not_yet", 64'(ram_ls), 64'd0);
    @(negedge clk); #1;
    chk("ls_entered", 64'(ram_ls), 64'd1);
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h10; #1;
    chk("ls_blocked", 64'(ifu_cmd_ready), 64'd0);
    @(negedge clk); #1;
    chk("wake_ls_low", 64'(ram_ls), 64'd0);
    chk("wake0_ready", 64'(ifu_cmd_ready), 64'd0);
    @(negedge clk); #1;
    chk("wake1_ready", 64'(ifu_cmd_ready), 64'd0);
    @(negedge clk); #1;
    chk("wake_done_ready", 64'(ifu_cmd_ready), 64'd1);
    chk("wake_done_cs", 64'(ram_cs), 64'd1);
    @(negedge clk); ifu_cmd_valid = 1'b0; cfg_ls_en = 1'b0; #1;
    chk("wake_rsp_data", ifu_rsp_rdata, W10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
